reg_rename_file: RTL and testbench

REG_RENAME_FILE -- requirements
Module: reg_rename_file

---
 rtl/reg_rename_file_pkg.sv | 14 +
 rtl/reg_rename_file_read_port.sv | 52 +++++
 rtl/reg_rename_file.sv | 90 +++++++++
 tb/tb_reg_rename_file.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/reg_rename_file_pkg.sv
// Shared core constants: register file geometry and reorder-buffer tag width.
package reg_rename_file_pkg;

  localparam int unsigned XLEN_DEF     = 32;
  localparam int unsigned REG_NUM_DEF  = 32;
  localparam int unsigned ROB_ID_W_DEF = 4;

  function automatic int unsigned idx_w(input int unsigned reg_num);
    return (reg_num > 1) ? $clog2(reg_num) : 1;
  endfunction

  localparam int unsigned REG_IDX_W = idx_w(REG_NUM_DEF);

endpackage

// File: rtl/reg_rename_file_read_port.sv
// One operand read path: looks up value/busy/tag and forwards a matching commit.
module rrf_read_port
  import reg_rename_file_pkg::*;
#(
  parameter int unsigned XLEN     = XLEN_DEF,
  parameter int unsigned REG_NUM  = REG_NUM_DEF,
  parameter int unsigned ROB_ID_W = ROB_ID_W_DEF,
  parameter int unsigned IDX_W    = REG_IDX_W
) (
  input  logic                               i_rdy,
  input  logic                               i_en,
  input  logic [IDX_W-1:0]                   i_rs,
  input  logic [REG_NUM-1:0]                 i_busy_vec,
  input  logic [REG_NUM-1:0][XLEN-1:0]       i_value_vec,
  input  logic [REG_NUM-1:0][ROB_ID_W-1:0]   i_tag_vec,
  input  logic                               i_commit_valid,
  input  logic [IDX_W-1:0]                   i_commit_rd,
  input  logic [ROB_ID_W-1:0]                i_commit_rob_id,
  input  logic [XLEN-1:0]                    i_commit_value,
  output logic                               o_busy,
  output logic [XLEN-1:0]                    o_value,
  output logic [ROB_ID_W-1:0]                o_rob_id
);

  logic                w_busy;
  logic [XLEN-1:0]     w_value;
  logic [ROB_ID_W-1:0] w_tag;
  logic                w_bypass;

  assign w_busy   = i_busy_vec[i_rs];
  assign w_value  = i_value_vec[i_rs];
  assign w_tag    = i_tag_vec[i_rs];
  // A commit held off by rdy=0 is not applied, so it must not be forwarded either.
  assign w_bypass = i_rdy & i_commit_valid & (i_commit_rd == i_rs) & (i_commit_rob_id == w_tag);

  always_comb begin
    o_busy   = 1'b0;
    o_value  = '0;
    o_rob_id = '0;
    if (i_en && (i_rs != '0)) begin
      if (!w_busy) begin
        o_value = w_value;
      end else if (w_bypass) begin
        o_value = i_commit_value;
      end else begin
        o_busy   = 1'b1;
        o_rob_id = w_tag;
      end
    end
  end

endmodule

// File: rtl/reg_rename_file.sv
// Architectural register file with rename tags: dispatch marks rd busy, commit
// writes the value and frees the register when the committing tag is current.
module reg_rename_file
  import reg_rename_file_pkg::*;
#(
  parameter int unsigned XLEN     = XLEN_DEF,
  parameter int unsigned REG_NUM  = REG_NUM_DEF,
  parameter int unsigned ROB_ID_W = ROB_ID_W_DEF,
  localparam int unsigned IDX_W   = idx_w(REG_NUM)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                rdy,
  input  logic                id_valid,
  input  logic                id_rd_en,
  input  logic [IDX_W-1:0]    id_rd,
  input  logic [ROB_ID_W-1:0] id_rob_id,
  input  logic                id_rs1_en,
  input  logic [IDX_W-1:0]    id_rs1,
  input  logic                id_rs2_en,
  input  logic [IDX_W-1:0]    id_rs2,
  output logic                rs1_busy,
  output logic [XLEN-1:0]     rs1_value,
  output logic [ROB_ID_W-1:0] rs1_rob_id,
  output logic                rs2_busy,
  output logic [XLEN-1:0]     rs2_value,
  output logic [ROB_ID_W-1:0] rs2_rob_id,
  input  logic                commit_valid,
  input  logic [IDX_W-1:0]    commit_rd,
  input  logic [ROB_ID_W-1:0] commit_rob_id,
  input  logic [XLEN-1:0]     commit_value,
  input  logic                rollback
);

  logic [REG_NUM-1:0]               r_busy;
  logic [REG_NUM-1:0][XLEN-1:0]     r_value;
  logic [REG_NUM-1:0][ROB_ID_W-1:0] r_tag;

  logic w_rename;
  logic w_commit;
  logic w_commit_clr;

  assign w_rename     = id_valid & id_rd_en & ~rollback & (id_rd != '0);
  assign w_commit     = commit_valid & (commit_rd != '0);
  // A same-cycle rename of the committing register keeps it busy under the new tag.
  assign w_commit_clr = (r_tag[commit_rd] == commit_rob_id) & ~(w_rename & (id_rd == commit_rd));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_busy  <= '0;
      r_value <= '0;
      r_tag   <= '0;
    end else if (rdy) begin
      if (rollback) begin
        r_busy <= '0;
      end
      if (w_commit) begin
        r_value[commit_rd] <= commit_value;
        if (w_commit_clr) begin
          r_busy[commit_rd] <= 1'b0;
        end
      end
      if (w_rename) begin
        r_busy[id_rd] <= 1'b1;
        r_tag[id_rd]  <= id_rob_id;
      end
    end
  end

  rrf_read_port #(
    .XLEN(XLEN), .REG_NUM(REG_NUM), .ROB_ID_W(ROB_ID_W), .IDX_W(IDX_W)
  ) u_rd1 (
    .i_rdy(rdy), .i_en(id_rs1_en), .i_rs(id_rs1),
    .i_busy_vec(r_busy), .i_value_vec(r_value), .i_tag_vec(r_tag),
    .i_commit_valid(commit_valid), .i_commit_rd(commit_rd),
    .i_commit_rob_id(commit_rob_id), .i_commit_value(commit_value),
    .o_busy(rs1_busy), .o_value(rs1_value), .o_rob_id(rs1_rob_id)
  );

  rrf_read_port #(
    .XLEN(XLEN), .REG_NUM(REG_NUM), .ROB_ID_W(ROB_ID_W), .IDX_W(IDX_W)
  ) u_rd2 (
    .i_rdy(rdy), .i_en(id_rs2_en), .i_rs(id_rs2),
    .i_busy_vec(r_busy), .i_value_vec(r_value), .i_tag_vec(r_tag),
    .i_commit_valid(commit_valid), .i_commit_rd(commit_rd),
    .i_commit_rob_id(commit_rob_id), .i_commit_value(commit_value),
    .o_busy(rs2_busy), .o_value(rs2_value), .o_rob_id(rs2_rob_id)
  );

endmodule

// File: tb/tb_reg_rename_file.sv
// Scoreboard bench for reg_rename_file: stimulus queues expected read results,
// a monitor samples both read ports mid-cycle and compares.
module tb_reg_rename_file;

  localparam int unsigned XLEN     = 32;
  localparam int unsigned REG_NUM  = 32;
  localparam int unsigned ROB_ID_W = 4;
  localparam int unsigned IDX_W    = 5;

  logic                clk;
  logic                rst;
  logic                rdy;
  logic                id_valid;
  logic                id_rd_en;
  logic [IDX_W-1:0]    id_rd;
  logic [ROB_ID_W-1:0] id_rob_id;
  logic                id_rs1_en;
  logic [IDX_W-1:0]    id_rs1;
  logic                id_rs2_en;
  logic [IDX_W-1:0]    id_rs2;
  logic                rs1_busy;
  logic [XLEN-1:0]     rs1_value;
  logic [ROB_ID_W-1:0] rs1_rob_id;
  logic                rs2_busy;
  logic [XLEN-1:0]     rs2_value;
  logic [ROB_ID_W-1:0] rs2_rob_id;
  logic                commit_valid;
  logic [IDX_W-1:0]    commit_rd;
  logic [ROB_ID_W-1:0] commit_rob_id;
  logic [XLEN-1:0]     commit_value;
  logic                rollback;

  typedef struct {
    string               name;
    int                  port;
    logic                busy;
    logic [XLEN-1:0]     value;
    logic [ROB_ID_W-1:0] rob;
    bit                  chk_rob;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  reg_rename_file #(.XLEN(XLEN), .REG_NUM(REG_NUM), .ROB_ID_W(ROB_ID_W)) dut (
    .clk(clk), .rst(rst), .rdy(rdy),
    .id_valid(id_valid), .id_rd_en(id_rd_en), .id_rd(id_rd), .id_rob_id(id_rob_id),
    .id_rs1_en(id_rs1_en), .id_rs1(id_rs1), .id_rs2_en(id_rs2_en), .id_rs2(id_rs2),
    .rs1_busy(rs1_busy), .rs1_value(rs1_value), .rs1_rob_id(rs1_rob_id),
    .rs2_busy(rs2_busy), .rs2_value(rs2_value), .rs2_rob_id(rs2_rob_id),
    .commit_valid(commit_valid), .commit_rd(commit_rd),
    .commit_rob_id(commit_rob_id), .commit_value(commit_value),
    .rollback(rollback)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic defaults();
    rdy = 1'b1; id_valid = 1'b0; id_rd_en = 1'b0; id_rd = '0; id_rob_id = '0;
    id_rs1_en = 1'b0; id_rs1 = '0; id_rs2_en = 1'b0; id_rs2 = '0;
    commit_valid = 1'b0; commit_rd = '0; commit_rob_id = '0; commit_value = '0;
    rollback = 1'b0;
  endtask

  task automatic next();
    @(negedge clk);
    defaults();
  endtask

  task automatic rename(input int rd, input int tag);
    id_valid = 1'b1; id_rd_en = 1'b1; id_rd = IDX_W'(rd); id_rob_id = ROB_ID_W'(tag);
  endtask

  task automatic commit(input int rd, input int tag, input logic [XLEN-1:0] val);
    commit_valid = 1'b1; commit_rd = IDX_W'(rd); commit_rob_id = ROB_ID_W'(tag); commit_value = val;
  endtask

  task automatic rd(input int port, input int rs, input string name, input logic b,
                    input logic [XLEN-1:0] v, input int r, input bit cr);
    exp_t e;
    if (port == 1) begin id_rs1_en = 1'b1; id_rs1 = IDX_W'(rs); end
    else begin id_rs2_en = 1'b1; id_rs2 = IDX_W'(rs); end
    e.name = name; e.port = port; e.busy = b; e.value = v; e.rob = ROB_ID_W'(r); e.chk_rob = cr;
    exp_q.push_back(e);
  endtask

  task automatic rd_off(input int port, input int rs, input string name);
    exp_t e;
    if (port == 1) begin id_rs1_en = 1'b0; id_rs1 = IDX_W'(rs); end
    else begin id_rs2_en = 1'b0; id_rs2 = IDX_W'(rs); end
    e.name = name; e.port = port; e.busy = 1'b0; e.value = '0; e.rob = '0; e.chk_rob = 1'b1;
    exp_q.push_back(e);
  endtask

  // Monitor: sample between edges, after stimulus has settled for this cycle.
  initial begin
    forever begin
      @(negedge clk);
      #2;
      while (exp_q.size() > 0) begin
        exp_t                e;
        logic                ab;
        logic [XLEN-1:0]     av;
        logic [ROB_ID_W-1:0] ar;
        e  = exp_q.pop_front();
        ab = (e.port == 1) ? rs1_busy   : rs2_busy;
        av = (e.port == 1) ? rs1_value  : rs2_value;
        ar = (e.port == 1) ? rs1_rob_id : rs2_rob_id;
        checks++;
        if (ab !== e.busy || av !== e.value || (e.chk_rob && ar !== e.rob)) begin
          errors++;
          $display("FAIL %s port%0d: got busy=%0b value=%h rob=%0d, expected busy=%0b value=%h rob=%0d%s",
                   e.name, e.port, ab, av, ar, e.busy, e.value, e.rob,
                   e.chk_rob ? "" : " (rob not checked)");
        end
      end
    end
  end

  initial begin
    logic [XLEN-1:0] v;
    rst = 1'b0;
    defaults();
    next(); next();
    rd(1, 5, "in_reset_x5", 1'b0, '0, 0, 1'b1);
    next(); rst = 1'b1;
    rd(1, 5, "after_reset_x5", 1'b0, '0, 0, 1'b1);
    rd_off(2, 5, "rs2_disabled");

    next(); rename(5, 3); rd(1, 5, "src_eq_rd_pre_rename", 1'b0, '0, 0, 1'b0);
    next(); rd(1, 5, "x5_busy_tag3", 1'b1, '0, 3, 1'b1);
    next(); commit(5, 3, 32'hDEAD);
    rd(1, 5, "x5_bypass_p1", 1'b0, 32'hDEAD, 0, 1'b0);
    rd(2, 5, "x5_bypass_p2", 1'b0, 32'hDEAD, 0, 1'b0);
    next(); rd(1, 5, "x5_after_commit", 1'b0, 32'hDEAD, 0, 1'b0);

    next(); rename(5, 3);
    next(); rename(5, 7); rd(1, 5, "x5_tag3_before_retag", 1'b1, '0, 3, 1'b1);
    next(); commit(5, 3, 32'h11); rd(1, 5, "x5_stale_commit_no_bypass", 1'b1, '0, 7, 1'b1);
    next(); rollback = 1'b1; rd(1, 5, "x5_still_busy_tag7", 1'b1, '0, 7, 1'b1);
    next(); rd(1, 5, "x5_stored_0x11", 1'b0, 32'h11, 0, 1'b0);

    next(); commit(6, 2, 32'h22); rename(6, 9); rd(1, 6, "x6_pre", 1'b0, '0, 0, 1'b0);
    next(); rd(1, 6, "x6_busy_tag9", 1'b1, '0, 9, 1'b1);
    next(); commit(6, 9, 32'h33); rd(1, 6, "x6_bypass_0x33", 1'b0, 32'h33, 0, 1'b0);
    next(); rd(1, 6, "x6_stored_0x33", 1'b0, 32'h33, 0, 1'b0);

    for (int i = 1; i < 32; i++) begin
      next(); rename(i, i % 16);
      if (i > 1) rd(2, i - 1, "rename_chain", 1'b1, '0, (i - 1) % 16, 1'b1);
    end
    next(); rollback = 1'b1; commit(4, 12, 32'h44); rename(7, 5);
    rd(1, 4, "x4_commit_tag_mismatch", 1'b1, '0, 4, 1'b1);
    rd(2, 31, "x31_busy_before_rollback", 1'b1, '0, 15, 1'b1);
    for (int i = 1; i < 32; i++) begin
      next();
      v = (i == 4) ? 32'h44 : (i == 5) ? 32'h11 : (i == 6) ? 32'h33 : 32'h0;
      rd(1, i, "post_rollback", 1'b0, v, 0, 1'b0);
    end

    next(); commit(0, 0, 32'hFF); rename(0, 1);
    rd(1, 0, "x0_during_write", 1'b0, '0, 0, 1'b1);
    next(); rd(1, 0, "x0_after_write_p1", 1'b0, '0, 0, 1'b1);
    rd(2, 0, "x0_after_write_p2", 1'b0, '0, 0, 1'b1);

    next(); rdy = 1'b0; rename(8, 1); commit(9, 0, 32'h99);
    rd(1, 9, "rdy0_commit_not_forwarded", 1'b0, '0, 0, 1'b0);
    next(); rd(1, 8, "rdy0_no_rename", 1'b0, '0, 0, 1'b0);
    rd(2, 9, "rdy0_no_commit", 1'b0, '0, 0, 1'b0);
    next(); rename(8, 1);
    next(); rdy = 1'b0; rollback = 1'b1; rd(1, 8, "x8_busy_rdy0", 1'b1, '0, 1, 1'b1);
    next(); rename(10, 2); rd(1, 8, "x8_rollback_ignored", 1'b1, '0, 1, 1'b1);
    next(); rd(2, 10, "x10_busy", 1'b1, '0, 2, 1'b1);
    next(); #1; rst = 1'b0;
    rd(1, 8, "async_reset_x8", 1'b0, '0, 0, 1'b1);
    rd(2, 4, "async_reset_x4", 1'b0, '0, 0, 1'b1);
    next(); rst = 1'b1;
    rd(1, 10, "post_reset_x10", 1'b0, '0, 0, 1'b1);
    rd(2, 6, "post_reset_x6", 1'b0, '0, 0, 1'b1);
    next(); next();

    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending, expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
